seven_segment_scanner: RTL and testbench

//  Multiplexed N-digit seven-segment driver: captures a packed hex value, then time-scans one digit per slot.

---
 rtl/seven_segment_scanner_pkg.sv | 21 ++
 rtl/seven_segment_scanner_decoder.sv | 13 +
 rtl/seven_segment_scanner.sv | 141 ++++++++++++++
 tb/tb_seven_segment_scanner.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seven_segment_scanner_pkg.sv
// Shared seven-segment constants: blank pattern, active-low hex table and helper functions.
// Used by seven_segment_scanner and seg_hex_decoder.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {a,b,c,d,e,f,g} patterns, bit6 = a
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit seven-segment scanner with dead-time and frame-aligned shadow updates.
// Optional macro LEADING_ZERO_BLANK_EN auto-blanks leading zero digits (digit 0 never blanked).
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16,
  localparam int IW = idx_width(NUM_DIGITS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      value_valid,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [IW-1:0]             digit_idx,
  output logic                      frame_start
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] P_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seven_segment_scanner: NUM_DIGITS must be 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("seven_segment_scanner: REFRESH_DIV must be >= 2");
  end
  if (DEAD_CYCLES < 0 || DEAD_CYCLES >= REFRESH_DIV) begin : g_bad_dead
    $error("seven_segment_scanner: DEAD_CYCLES must be < REFRESH_DIV");
  end

  logic [PW-1:0]           p;
  logic                    tick;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] shad_val;
  logic [NUM_DIGITS-1:0]   shad_blank;
  logic [NUM_DIGITS-1:0]   shad_dp;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              dec_seg;
  logic                    in_dead;

  assign tick    = (p == P_LAST);
  assign wrap    = tick && (digit_idx == IDX_LAST);
  assign in_dead = (DEAD_CYCLES > 0) && (int'(p) < DEAD_CYCLES);

  // Shadow only changes on the frame wrap so a frame never mixes old and new digits
  always_ff @(posedge clk) begin
    if (rst) begin
      p           <= '0;
      digit_idx   <= '0;
      frame_start <= 1'b0;
      pend_val    <= '0;
      pend_blank  <= '0;
      pend_dp     <= '0;
      shad_val    <= '0;
      shad_blank  <= '0;
      shad_dp     <= '0;
    end else begin
      p           <= tick ? '0 : p + 1'b1;
      frame_start <= wrap;
      if (tick) begin
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end
      if (value_valid) begin
        pend_val   <= value_in;
        pend_blank <= blank_in;
        pend_dp    <= dp_in;
      end
      if (wrap) begin
        shad_val   <= value_valid ? value_in : pend_val;
        shad_blank <= value_valid ? blank_in : pend_blank;
        shad_dp    <= value_valid ? dp_in    : pend_dp;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic all_zero;

  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero    = all_zero & (shad_val[4*i +: 4] == 4'h0);
      lz_blank[i] = all_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    an_next   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        cur_nib    = shad_val[4*i +: 4];
        cur_blank  = shad_blank[i] | lz_blank[i];
        cur_dp     = shad_dp[i];
        an_next[i] = 1'b0;
      end
    end
  end

  seg_hex_decoder u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else if (in_dead) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= cur_blank ? SEG_BLANK : dec_seg;
      dp  <= ~cur_dp;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed self-checking bench for seven_segment_scanner (4 digits, 8-cycle slots, 1 dead cycle).
module tb_seven_segment_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  blank_in;
  logic [3:0]  dp_in;
  logic        value_valid;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  logic [6:0] hex_tab [16];
  logic [6:0] d2_exp;

  seven_segment_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .DEAD_CYCLES (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .blank_in    (blank_in),
    .dp_in       (dp_in),
    .value_valid (value_valid),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dps, input logic [3:0] blanks);
    value_in    = v;
    dp_in       = dps;
    blank_in    = blanks;
    value_valid = 1'b1;
  endtask

  // Returns just after the edge that raises frame_start
  task automatic waitFrame();
    bit seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge clk); #1;
      value_valid = 1'b0;
      if (frame_start) seen = 1;
    end
    if (!seen) checkOutput("frame_timeout", 0, 1);
  endtask

  // Walks one 32-cycle frame starting just after a wrap edge; optional write at cycle write_at
  task automatic runFrame(input logic [27:0] exp_seg, input logic [3:0] exp_dp,
                          input int write_at, input logic [15:0] wv,
                          input logic [3:0] wdp, input logic [3:0] wblank);
    for (int c = 1; c <= 32; c++) begin
      int k;
      int ph;
      @(posedge clk); #1;
      value_valid = 1'b0;
      k  = (c - 1) / 8;
      ph = (c - 1) % 8;
      if (ph == 0) begin
        checkOutput($sformatf("dead%0d_an", k), 32'(an), 32'h0F);
        checkOutput($sformatf("dead%0d_seg", k), 32'(seg), 32'h7F);
      end else if (ph == 1) begin
        checkOutput($sformatf("d%0d_an", k), 32'(an), 32'(4'hF & ~(4'd1 << k)));
        checkOutput($sformatf("d%0d_seg", k), 32'(seg), 32'(exp_seg[7*k +: 7]));
        checkOutput($sformatf("d%0d_dp", k), 32'(dp), 32'(exp_dp[k]));
        checkOutput($sformatf("d%0d_idx", k), 32'(digit_idx), k);
      end
      if (c == 1)  checkOutput("fs_low", 32'(frame_start), 0);
      if (c == 32) checkOutput("fs_period", 32'(frame_start), 1);
      if (c == write_at) applyStimulus(wv, wdp, wblank);
    end
  endtask

  initial begin
    hex_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
`ifdef LEADING_ZERO_BLANK_EN
    d2_exp = 7'h7F;
`else
    d2_exp = 7'h01;
`endif
    rst         = 1'b1;
    value_in    = '0;
    blank_in    = '0;
    dp_in       = '0;
    value_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset held mid-scan
    repeat (13) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_seg", 32'(seg), 32'h7F);
      checkOutput("rst_an", 32'(an), 32'hF);
      checkOutput("rst_dp", 32'(dp), 1);
      checkOutput("rst_idx", 32'(digit_idx), 0);
      checkOutput("rst_fs", 32'(frame_start), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_dead_an", 32'(an), 32'hF);
    @(posedge clk); #1;
    checkOutput("post_rst_an", 32'(an), 32'hE);
    checkOutput("post_rst_seg", 32'(seg), 32'(d2_exp == 7'h7F ? 7'h01 : 7'h01));
    checkOutput("post_rst_idx", 32'(digit_idx), 0);

    // 1234 loaded at the next wrap; ABCD written mid-frame must wait a frame
    applyStimulus(16'h1234, 4'h0, 4'h0);
    waitFrame();
    runFrame({7'h4F, 7'h12, 7'h06, 7'h4C}, 4'hF, 10, 16'hABCD, 4'h0, 4'h0);

    // Write on the wrap-tick cycle bypasses straight into the next frame
    runFrame({7'h08, 7'h60, 7'h31, 7'h42}, 4'hF, 31, 16'h0050, 4'b0010, 4'b1000);
    runFrame({7'h7F, d2_exp, 7'h24, 7'h01}, 4'b1101, 20, 16'h8880, 4'h0, 4'h0);

    // Sweep every nibble through digit 0
    for (int n = 0; n < 16; n++) begin
      runFrame({7'h00, 7'h00, 7'h00, hex_tab[n]}, 4'hF, (n < 15) ? 20 : -1,
               {12'h888, 4'(n + 1)}, 4'h0, 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
